// File: rtl/main_memory_pkg.sv
// main_memory_pkg
// Shared definitions for the main memory block: default geometry, the
// controller state encoding and the even-parity helper used when the
// optional parity feature (MAIN_MEM_PARITY_EN) is compiled in.
package main_memory_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  typedef enum logic {
    INIT = 1'b0,  // post-reset clear sweep, busy=1
    IDLE = 1'b1   // serving requests
  } state_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/main_memory_array.sv
// main_memory_array
// Storage array: one write port and one registered read port sharing a
// single address. The read register clears on reset so the data output
// starts at 0; the array contents themselves are never reset.
//
// Ports:
//   clk    in  1        clock
//   reset  in  1        synchronous active-high reset (read register only)
//   we     in  1        write enable
//   re     in  1        read enable; loads the read register
//   addr   in  ADDR_W   word address
//   wdata  in  W        write word
//   rdata  out W        registered read word; holds between reads
module main_memory_array #(
  parameter int W      = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [2**ADDR_W];
  logic [W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/main_memory.sv
// main_memory
// Single-port word-addressed main memory with a req/ack handshake and
// one-cycle latency. After reset it sweeps every word to zero (busy=1)
// before accepting requests. Scan pins are placeholders for chains that
// synthesis stitches in; the RTL ties their outputs low.
//
// Optional feature macro: MAIN_MEM_PARITY_EN
//   adds a stored even-parity bit per word, input par_inj (invert the
//   stored parity on a write) and output par_err (parity mismatch on read).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, we, addr, wdata  request (held until ack), write flag, address, data
//   ack                   one-cycle completion pulse
//   rdata                 read data, valid with ack on a read, else held
//   busy                  high during the post-reset clear
//   scan_in0..4, scan_enable, test_mode   scan/DFT inputs, unused in RTL
//   scan_out0..4          scan outputs, tied to 0
//   par_inj, par_err      parity inject / error (MAIN_MEM_PARITY_EN only)
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
`ifdef MAIN_MEM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4
);

`ifdef MAIN_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] counter_reg, counter_next;
  logic              ack_reg, ack_next;
  logic              rd_reg, rd_next;     // the access being acked is a read
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata, write_word;

`ifdef MAIN_MEM_PARITY_EN
  assign write_word = {parity(PAR_MAX_W'(wdata)) ^ par_inj, wdata};
`else
  assign write_word = wdata;
`endif

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    ack_next     = 1'b0;
    rd_next      = rd_reg;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = addr;
    mem_wdata    = write_word;
    case (state_reg)
      INIT: begin
        // Zero word (parity 0 is consistent with all-zero data).
        mem_we       = 1'b1;
        mem_addr     = counter_reg;
        mem_wdata    = '0;
        counter_next = counter_reg + 1'b1;
        if (counter_reg == {ADDR_W{1'b1}}) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        // ack high blocks acceptance, enforcing the 2-cycle request spacing.
        if (req && !ack_reg) begin
          ack_next = 1'b1;
          rd_next  = !we;
          mem_we   = we;
          mem_re   = !we;
        end
      end
      default: state_next = INIT;
    endcase
    // Contents must stay untouched at a reset edge.
    if (reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= INIT;
      counter_reg <= '0;
      ack_reg     <= 1'b0;
      rd_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      ack_reg     <= ack_next;
      rd_reg      <= rd_next;
    end
  end

  main_memory_array #(
    .W      (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign ack   = ack_reg;
  assign busy  = (state_reg == INIT);
  assign rdata = mem_rdata[DATA_W-1:0];

`ifdef MAIN_MEM_PARITY_EN
  // Derived from the read register and ack/read flags, so it changes only
  // at the edge that loads rdata and is gated to the read's ack cycle.
  assign par_err = ack_reg && rd_reg &&
                   (parity(PAR_MAX_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`endif

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        par_inj;
`ifdef MAIN_MEM_PARITY_EN
  logic        par_err;
`endif
  logic        so0, so1, so2, so3, so4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        rd;
    logic [15:0] rdata;
    logic        pe;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  main_memory dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
`ifdef MAIN_MEM_PARITY_EN
    .par_inj     (par_inj),
    .par_err     (par_err),
`endif
    .scan_in0    (1'b1),
    .scan_in1    (1'b0),
    .scan_in2    (1'b1),
    .scan_in3    (1'b0),
    .scan_in4    (1'b1),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (so0),
    .scan_out1   (so1),
    .scan_out2   (so2),
    .scan_out3   (so3),
    .scan_out4   (so4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reset held for n cycles; outputs checked after the first reset edge.
  task automatic do_reset(input int n);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_ack", ack, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_busy", busy, 1);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic wait_init(output int cyc, output bit ack_seen);
    cyc = 0;
    ack_seen = 0;
    while (busy && cyc < 1000) begin
      if (ack) ack_seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic inj, input logic [15:0] exp_rd, input logic exp_pe);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back('{rd: !w, rdata: exp_rd, pe: exp_pe});
    req = 1'b1; we = w; addr = a; wdata = d; par_inj = inj;
    got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      if (ack) got = 1;
      else lat++;
    end
    req = 1'b0; we = 1'b0; par_inj = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk("ack_timeout", 0, 1);
    end else begin
      chk("ack_latency", lat, 0);
      chk(e.rd ? "read_rdata" : "write_rdata_hold", rdata, e.rdata);
`ifdef MAIN_MEM_PARITY_EN
      chk("par_err", par_err, e.pe);
`endif
    end
    $display("txn %s addr=%02h wdata=%04h inj=%0b rdata=%04h exp=%04h exp_pe=%0b",
             w ? "WR" : "RD", a, d, inj, rdata, e.rdata, e.pe);
    @(posedge clk); #1;
    chk("ack_pulse", ack, 0);
  endtask

  initial begin
    int cyc;
    bit ack_seen;

    vecs[0] = '{w: 1'b1, a: 8'h10, d: 16'hA5A5, exp_rdata: 16'h0000};
    vecs[1] = '{w: 1'b0, a: 8'h10, d: 16'h0000, exp_rdata: 16'hA5A5};
    vecs[2] = '{w: 1'b1, a: 8'h05, d: 16'h1234, exp_rdata: 16'hA5A5};
    vecs[3] = '{w: 1'b0, a: 8'h05, d: 16'hFFFF, exp_rdata: 16'h1234};
    vecs[4] = '{w: 1'b0, a: 8'h80, d: 16'h0000, exp_rdata: 16'h0000};
    vecs[5] = '{w: 1'b1, a: 8'hFF, d: 16'hFFFF, exp_rdata: 16'h0000};
    vecs[6] = '{w: 1'b0, a: 8'hFF, d: 16'h0000, exp_rdata: 16'hFFFF};
    vecs[7] = '{w: 1'b1, a: 8'h10, d: 16'h0F0F, exp_rdata: 16'hFFFF};
    vecs[8] = '{w: 1'b0, a: 8'h10, d: 16'h0000, exp_rdata: 16'h0F0F};
    vecs[9] = '{w: 1'b0, a: 8'h05, d: 16'h0000, exp_rdata: 16'h1234};

    req = 0; we = 0; addr = 0; wdata = 0; par_inj = 0; reset = 0;
    @(posedge clk); #1;

    // Power-up: reset, then the clear sweep.
    do_reset(2);
    chk("scan_out", {27'd0, so4, so3, so2, so1, so0}, 0);
    wait_init(cyc, ack_seen);
    chk("init_busy_cycles", cyc, 256);
    chk("init_no_ack", ack_seen, 0);
    access(1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Table-driven accesses.
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, vecs[i].exp_rdata, 1'b0);
    end

    // req held continuously: ack alternates 1,0,1,0.
    req = 1'b1; we = 1'b0; addr = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", ack, (i % 2 == 0) ? 1 : 0);
      if (ack) chk("b2b_rdata", rdata, 16'h0F0F);
      $display("txn RD b2b addr=10 ack=%0b rdata=%04h", ack, rdata);
    end
    req = 1'b0;
    @(posedge clk); #1;

    // Reset mid-INIT restarts the sweep; earlier write is cleared.
    access(1'b1, 8'h05, 16'h1234, 1'b0, 16'h0F0F, 1'b0);
    do_reset(2);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_init_busy", busy, 1);
    do_reset(2);
    wait_init(cyc, ack_seen);
    chk("restart_busy_cycles", cyc, 256);
    chk("restart_no_ack", ack_seen, 0);
    access(1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Request held during INIT: ignored until busy drops, then accepted.
    do_reset(2);
    req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 16'h5555;
    wait_init(cyc, ack_seen);
    chk("req_init_busy_cycles", cyc, 256);
    chk("req_init_no_ack", ack_seen, 0);
    @(posedge clk); #1;
    chk("req_after_init_ack", ack, 1);
    $display("txn WR held-during-init addr=30 wdata=5555 ack=%0b", ack);
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 8'h30, 16'h0000, 1'b0, 16'h5555, 1'b0);
    access(1'b0, 8'h31, 16'h0000, 1'b0, 16'h0000, 1'b0);

`ifdef MAIN_MEM_PARITY_EN
    access(1'b1, 8'h20, 16'h0001, 1'b1, 16'h0000, 1'b0);
    access(1'b0, 8'h20, 16'h0000, 1'b0, 16'h0001, 1'b1);
    access(1'b1, 8'h21, 16'h0003, 1'b0, 16'h0001, 1'b0);
    access(1'b0, 8'h21, 16'h0000, 1'b0, 16'h0003, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
